// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   NREG/AW/DW : architectural register count, address width, data width
//   REQ_ALU/REQ_LSU : requester identifiers, also used as the round-robin pointer value
//   wb_req_t   : one queued writeback (destination register + data)
package rf_pkg;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous writeback FIFO, DEPTH entries (power of two, >= 2).
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   push, push_rd/data    : producer side; an entry is taken when push && ready
//   ready                 : count < DEPTH, from registered count only
//   pop, head_rd/data     : consumer side; pop must only be raised when not_empty
//   not_empty             : at least one entry held
//   occ_mask              : one-hot OR of rd over all held entries, x0 excluded
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREG  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [AW-1:0]   push_rd,
    input  logic [DW-1:0]   push_data,
    output logic            ready,
    input  logic            pop,
    output logic [AW-1:0]   head_rd,
    output logic [DW-1:0]   head_data,
    output logic            not_empty,
    output logic [NREG-1:0] occ_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0]    mem_rd   [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign ready     = (count < FULL);
    assign not_empty = (count != '0);
    assign do_push   = push && ready;
    assign do_pop    = pop && not_empty;
    assign head_rd   = mem_rd[rptr];
    assign head_data = mem_data[rptr];

    // Storage needs no reset: vld qualifies every entry.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_rd[wptr]   <= push_rd;
            mem_data[wptr] <= push_data;
        end
    end

    // Push and pop never target the same slot in one edge: equal pointers
    // mean either empty (no pop) or full (no push).
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (do_push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        occ_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem_rd[i] != '0)) occ_mask[mem_rd[i]] = 1'b1;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU and LSU writeback paths.
//   clock, reset                    : rising-edge clock, synchronous active-high reset
//   alu_valid/rd/data, alu_ready    : ALU writeback handshake into its FIFO
//   lsu_valid/rd/data, lsu_ready    : LSU writeback handshake into its FIFO
//   wr_en, wr_addr, wr_data         : registered register-file write port
//   pend_mask                       : registers with a queued or in-flight write
//   idle                            : both FIFOs empty and no write in flight
module rf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREG  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [DW-1:0]   lsu_data,
    output logic            lsu_ready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] pend_mask,
    output logic            idle
);
    import rf_pkg::*;

    logic            alu_pop, lsu_pop, alu_ne, lsu_ne, gnt_any;
    logic [AW-1:0]   alu_head_rd, lsu_head_rd, gnt_rd;
    logic [DW-1:0]   alu_head_data, lsu_head_data, gnt_data;
    logic [NREG-1:0] alu_occ, lsu_occ, wr_onehot;
    logic            last_gnt;

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NREG(NREG)) u_alu_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (alu_valid),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .ready     (alu_ready),
        .pop       (alu_pop),
        .head_rd   (alu_head_rd),
        .head_data (alu_head_data),
        .not_empty (alu_ne),
        .occ_mask  (alu_occ)
    );

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NREG(NREG)) u_lsu_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (lsu_valid),
        .push_rd   (lsu_rd),
        .push_data (lsu_data),
        .ready     (lsu_ready),
        .pop       (lsu_pop),
        .head_rd   (lsu_head_rd),
        .head_data (lsu_head_data),
        .not_empty (lsu_ne),
        .occ_mask  (lsu_occ)
    );

    // ALU wins when alone or when LSU was served last; LSU takes everything else.
    always_comb begin
        alu_pop  = alu_ne && (!lsu_ne || (last_gnt == REQ_LSU));
        lsu_pop  = lsu_ne && !alu_pop;
        gnt_any  = alu_pop || lsu_pop;
        gnt_rd   = lsu_pop ? lsu_head_rd   : alu_head_rd;
        gnt_data = lsu_pop ? lsu_head_data : alu_head_data;
    end

    // A grant to x0 still pops and advances the pointer but never writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            last_gnt <= REQ_LSU;
        end else begin
            wr_en <= gnt_any && (gnt_rd != '0);
            if (gnt_any) begin
                wr_addr  <= gnt_rd;
                wr_data  <= gnt_data;
                last_gnt <= lsu_pop ? REQ_LSU : REQ_ALU;
            end
        end
    end

    always_comb begin
        wr_onehot = '0;
        if (wr_en) wr_onehot[wr_addr] = 1'b1;
    end

    assign pend_mask = alu_occ | lsu_occ | wr_onehot;
    assign idle      = !alu_ne && !lsu_ne && !wr_en;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, 5-bit write address, 32-bit write data) between two writeback requesters: ALU (req 0) and load/store unit (req 1).
- Each requester gets a small FIFO and a valid/ready handshake. A round-robin arbiter drains the FIFOs into a registered write port.
- Exports a pending-write mask so decode/hazard logic can stall reads of registers that have queued writes.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, number of architectural registers (width of pend_mask)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU FIFO can accept
- lsu_valid  in  1  LSU writeback request
- lsu_rd  in  AW  LSU destination register
- lsu_data  in  DW  load data
- lsu_ready  out  1  LSU FIFO can accept
- wr_en  out  1  to register file write enable
- wr_addr  out  AW  to register file write address
- wr_data  out  DW  to register file write data
- pend_mask  out  NREG  bit r set when any queued or in-flight write targets r
- idle  out  1  both FIFOs empty and wr_en low

Behaviour:
- Reset values (synchronous, takes priority over all other activity):
  - wr_en=0, wr_addr=0, wr_data=0; FIFOs empty; all pointers and counts 0.
  - RR pointer = LSU last granted, so ALU wins the first tie.
  - Consequently alu_ready=lsu_ready=1, pend_mask=0, idle=1 in the first cycle after reset.
  - Reset mid-operation discards all queued entries and any pending wr_en. No write reaches the register file on the edge after reset is sampled.
- Handshake:
  - Transfer occurs on a rising edge where valid && ready.
  - ready = (count < DEPTH). It is a function of registered count only and does not depend on same-cycle pop (no comb path from arbiter to ready).
  - valid without ready: producer holds rd/data stable. The block does not drop data.
- Arbitration (combinational on FIFO-not-empty flags, registered result):
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the one not granted last. The RR pointer updates only on a grant.
  - On the granting edge, pop the head and register wr_en/wr_addr/wr_data.
- x0 handling: a head entry with rd==0 is popped and counts as a grant, but the registered wr_en is 0 (wr_addr/wr_data may update). x0 never appears in pend_mask.
- Latency: accepted at edge E0 → wr_en high in the cycle after E1 (if no contention) → register file write at E2. Under continuous contention each requester is served at least every 2nd cycle.
- Throughput: one write per cycle max.
- Simultaneous push and pop on the same FIFO in one edge: count unchanged, both take effect. Pointers wrap modulo DEPTH.
- pend_mask: OR over all valid FIFO entries' one-hot(rd), plus one-hot(wr_addr) when wr_en=1. Registered or derived from registered state only. Duplicates to the same rd keep the bit set until the last one completes.
- Ordering: per-requester order preserved. Between requesters the order is arbitration order; producers that need cross-unit ordering on the same rd use pend_mask.

Decomposition:
- Shared package rf_pkg holds:
  - constants: NREG, AW, DW, REQ_ALU=0, REQ_LSU=1
  - typedef wb_req_t {rd, data}
- Natural sub-module: wb_fifo (parameterised DEPTH sync FIFO with count and a per-entry valid/rd vector for pend_mask). The arbiter instantiates it twice.

Test Plan:
- Reset, then single ALU write x5=0xDEADBEEF → accepted at E0, wr_en=1/wr_addr=5/wr_data=0xDEADBEEF in the cycle after E1 only; pend_mask[5]=1 from after E0 until wr_en drops; idle returns to 1.
- Both requesters valid every cycle (ALU x1..x4, LSU x11..x14) → grants alternate ALU,LSU,ALU,… starting with ALU; 8 writes in 8 consecutive cycles; per-source order kept.
- Stall LSU drain by keeping ALU busy, push 3 LSU entries with DEPTH=2 → lsu_ready=0 after 2 accepts; third held until a pop; no loss or duplication.
- ALU writes rd=0 data=0x1234 → FIFO pops, wr_en stays 0, pend_mask unchanged.
- Two ALU writes to x7 (0x1, then 0x2) → both appear in order; pend_mask[7] stays 1 until the second completes.
- Fill both FIFOs, assert reset for one cycle → no wr_en afterwards, ready=1, pend_mask=0, idle=1.
